// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the AHB-lite SPI target block:
//   - register word indices (haddr[4:2])
//   - CR / SR bit positions
//   - core FSM state encoding
//   - registered AHB address-phase request
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    // Register word index = haddr[4:2]
    localparam logic [2:0] REG_CR   = 3'd0;
    localparam logic [2:0] REG_SR   = 3'd1;
    localparam logic [2:0] REG_TXDR = 3'd2;
    localparam logic [2:0] REG_RXDR = 3'd3;

    // CR bits
    localparam int CR_EN    = 0;
    localparam int CR_CPOL  = 1;
    localparam int CR_CPHA  = 2;
    localparam int CR_RXIE  = 3;
    localparam int CR_TXIE  = 4;
    localparam int CR_ERRIE = 5;

    // SR bits
    localparam int SR_RXNE = 0;
    localparam int SR_TXE  = 1;
    localparam int SR_BUSY = 2;
    localparam int SR_OVR  = 3;
    localparam int SR_FERR = 4;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Address-phase capture, consumed in the following data phase
    typedef struct packed {
        logic [2:0] addr;
        logic       we;
        logic       re;
    } ahb_req_t;

    function automatic logic ahb_xfer(input logic sel, input logic [1:0] trans);
        return sel && (trans != HTRANS_IDLE);
    endfunction

endpackage

// File: rtl/spi_slave_core.sv
// -----------------------------------------------------------------------------
// spi_slave_core
// SPI target engine running entirely on clk. SCK/CS_N/MOSI are oversampled
// through 2-FF synchronizers; edges are detected between stages 2 and 3, so an
// input change acts 3 clk later.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en, cpol, cpha    mode controls from CR
//   spi_sck/cs_n/mosi asynchronous SPI inputs
//   tx_avail, tx_data next transmit word (tx_avail=0 -> DUMMY is sent)
//   tx_load           strobe: tx_shift is (re)loaded this cycle
//   rx_valid, rx_data strobe + completed receive word
//   busy              frame in progress (ACTIVE)
//   ferr_set          strobe: CS released with a partial frame
//   spi_miso, miso_oe serial output and its enable
// -----------------------------------------------------------------------------
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int          DW    = 8,
    parameter logic [31:0] DUMMY = 32'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          spi_sck,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    input  logic          tx_avail,
    input  logic [DW-1:0] tx_data,
    output logic          tx_load,
    output logic          rx_valid,
    output logic [DW-1:0] rx_data,
    output logic          busy,
    output logic          ferr_set,
    output logic          spi_miso,
    output logic          miso_oe
);

    localparam int             CW   = $clog2(DW);
    localparam logic [CW-1:0]  LAST = CW'(DW - 1);

    logic [2:0]    sck_sync;
    logic [2:0]    cs_sync;
    logic [1:0]    mosi_sync;
    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] tx_shift;
    logic          skip_shift;

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
    logic lead, trail, sample_edge, shift_edge, active, last_bit;
    logic [DW-1:0] load_val;

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign cs_rise  = cs_sync[1] & ~cs_sync[2];
    // mosi stage 2 lines up with the sck stage used for edge detection
    assign mosi_s   = mosi_sync[1];

    assign lead        = cpol ? sck_fall : sck_rise;
    assign trail       = cpol ? sck_rise : sck_fall;
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead  : trail;

    assign active   = (state == ST_ACTIVE);
    assign last_bit = (bit_cnt == LAST);
    assign load_val = tx_avail ? tx_data : DUMMY[DW-1:0];

    // Combinational strobes so the register file updates in the same cycle
    assign rx_valid = en & active & ~cs_rise & sample_edge & last_bit;
    assign tx_load  = (en & ~active & cs_fall) | rx_valid;
    assign ferr_set = en & active & cs_rise & (bit_cnt != '0);
    assign rx_data  = {rx_shift, mosi_s};
    assign busy     = active;
    assign spi_miso = tx_shift[DW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync   <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            skip_shift <= 1'b0;
            miso_oe    <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            miso_oe   <= en & ~cs_sync[1];

            if (!en) begin
                // Disable aborts silently: no flags raised
                state      <= ST_IDLE;
                bit_cnt    <= '0;
                skip_shift <= 1'b0;
            end else if (!active) begin
                if (cs_fall) begin
                    state      <= ST_ACTIVE;
                    bit_cnt    <= '0;
                    tx_shift   <= load_val;
                    // CPHA=1: first lead must present the MSB, not shift past it
                    skip_shift <= cpha;
                end
            end else if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[DW-3:0], mosi_s};
                if (last_bit) begin
                    bit_cnt    <= '0;
                    tx_shift   <= load_val;
                    // A reload happens on a sample edge in both modes; the next
                    // shift edge would otherwise push out the new MSB unseen.
                    skip_shift <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (shift_edge) begin
                if (skip_shift) skip_shift <= 1'b0;
                else            tx_shift   <= {tx_shift[DW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_slave_ahb.sv
// -----------------------------------------------------------------------------
// spi_slave_ahb
// AHB-lite register front-end for an SPI target port. Zero wait state.
// Ports:
//   hclk, hreset            clock, synchronous active-high reset
//   haddr/hwdata/hrdata     AHB address, write data, read data
//   hsel/hwrite/htrans      transfer qualifiers (hsize/hburst ignored)
//   hresp/hready            tied OKAY / ready
//   irq                     registered level interrupt
//   spi_sck/cs_n/mosi/miso  SPI target pins, miso_oe output enable
// Registers: CR 0x00, SR 0x04, TXDR 0x08 (wo), RXDR 0x0C (ro).
// -----------------------------------------------------------------------------
module spi_slave_ahb
    import spi_slave_pkg::*;
#(
    parameter int          DW    = 8,
    parameter logic [31:0] DUMMY = 32'hFF
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [4:0]  haddr,
    output logic [31:0] hrdata,
    input  logic [31:0] hwdata,
    input  logic        hsel,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    output logic [1:0]  hresp,
    output logic        hready,
    output logic        irq,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        miso_oe
);

    ahb_req_t      req_q;
    logic [5:0]    cr;
    logic [DW-1:0] txdr, rxdr;
    logic          rxne, txe, ovr, ferr;

    logic          xfer, wr_cr, wr_sr, wr_txdr, rd_rxdr;
    logic          tx_load, rx_valid, busy, ferr_set, rx_store, rx_drop;
    logic [DW-1:0] rx_data, tx_word;
    logic          unused_ok;

    assign xfer    = ahb_xfer(hsel, htrans);
    assign wr_cr   = req_q.we && (req_q.addr == REG_CR);
    assign wr_sr   = req_q.we && (req_q.addr == REG_SR);
    assign wr_txdr = req_q.we && (req_q.addr == REG_TXDR);
    assign rd_rxdr = req_q.re && (req_q.addr == REG_RXDR);

    // A TXDR write landing in the load cycle is forwarded straight into the
    // shifter, so the frame carries the fresh value and TXE ends up set.
    assign tx_word = wr_txdr ? hwdata[DW-1:0] : txdr;

    // A read of RXDR in the completion cycle frees the slot for the new word
    assign rx_store = rx_valid & (~rxne | rd_rxdr);
    assign rx_drop  = rx_valid & rxne & ~rd_rxdr;

    assign hresp     = 2'b00;
    assign hready    = 1'b1;
    assign unused_ok = ^{hsize, hburst, haddr[1:0], hwdata};

    spi_slave_core #(.DW(DW), .DUMMY(DUMMY)) u_core (
        .clk      (hclk),
        .rst      (hreset),
        .en       (cr[CR_EN]),
        .cpol     (cr[CR_CPOL]),
        .cpha     (cr[CR_CPHA]),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .tx_avail (wr_txdr | ~txe),
        .tx_data  (tx_word),
        .tx_load  (tx_load),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .ferr_set (ferr_set),
        .spi_miso (spi_miso),
        .miso_oe  (miso_oe)
    );

    always_comb begin
        hrdata = '0;
        if (req_q.re) begin
            case (req_q.addr)
                REG_CR:   hrdata = 32'(cr);
                REG_SR: begin
                    hrdata[SR_RXNE] = rxne;
                    hrdata[SR_TXE]  = txe;
                    hrdata[SR_BUSY] = busy;
                    hrdata[SR_OVR]  = ovr;
                    hrdata[SR_FERR] = ferr;
                end
                REG_RXDR: hrdata = 32'(rxdr);
                default:  hrdata = '0;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            req_q <= '0;
            cr    <= '0;
            txdr  <= '0;
            rxdr  <= '0;
            rxne  <= 1'b0;
            txe   <= 1'b1;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            req_q.we <= xfer & hwrite;
            req_q.re <= xfer & ~hwrite;
            if (xfer) req_q.addr <= haddr[4:2];

            if (wr_cr)   cr   <= hwdata[5:0];
            if (wr_txdr) txdr <= hwdata[DW-1:0];

            if (tx_load)      txe <= 1'b1;
            else if (wr_txdr) txe <= 1'b0;

            if (rx_store) begin
                rxdr <= rx_data;
                rxne <= 1'b1;
            end else if (rd_rxdr) begin
                rxne <= 1'b0;
            end

            if (rx_drop)                      ovr <= 1'b1;
            else if (wr_sr && hwdata[SR_OVR]) ovr <= 1'b0;

            if (ferr_set)                      ferr <= 1'b1;
            else if (wr_sr && hwdata[SR_FERR]) ferr <= 1'b0;

            irq <= (cr[CR_RXIE] & rxne) | (cr[CR_TXIE] & txe) |
                   (cr[CR_ERRIE] & (ovr | ferr));
        end
    end

endmodule

// File: tb/tb_spi_slave_ahb.sv
module tb_spi_slave_ahb;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic [4:0]  haddr = '0;
    logic [31:0] hrdata;
    logic [31:0] hwdata = '0;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic [2:0]  hburst = 3'b000;
    logic [1:0]  hresp;
    logic        hready;
    logic        irq;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        miso_oe;

    int   checks = 0;
    int   failures = 0;
    logic cpol_m = 1'b0;
    logic cpha_m = 1'b0;

    always #5 hclk = ~hclk;

    spi_slave_ahb dut (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .hrdata(hrdata),
        .hwdata(hwdata), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hresp(hresp), .hready(hready),
        .irq(irq), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .miso_oe(miso_oe)
    );

    task automatic ahb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge hclk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(posedge hclk); #1;
    endtask

    task automatic ahb_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge hclk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
        @(posedge hclk); #1;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        cpol_m = cpol; cpha_m = cpha;
        @(negedge hclk);
        spi_sck = cpol;
        repeat (4) @(posedge hclk);
    endtask

    task automatic cs_low();
        @(negedge hclk);
        spi_cs_n = 1'b0;
        #50;
    endtask

    task automatic cs_high();
        #50;
        spi_cs_n = 1'b1;
        repeat (6) @(posedge hclk);
        #1;
    endtask

    // SPI master, 10 MHz SCK: n bits of mo (MSB first), returns MISO bits
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        int i;
        mi = '0;
        for (int k = 0; k < n; k++) begin
            i = 7 - k;
            if (!cpha_m) begin
                spi_mosi = mo[i];
                #50;
                mi[i] = spi_miso;
                spi_sck = ~cpol_m;
                #50;
                spi_sck = cpol_m;
            end else begin
                spi_sck = ~cpol_m;
                spi_mosi = mo[i];
                #50;
                mi[i] = spi_miso;
                spi_sck = cpol_m;
                #50;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        hreset = 1'b1;
        repeat (3) @(posedge hclk);
        #1;
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        checks++; if ({irq, spi_miso, miso_oe} !== 3'b000) begin failures++; $display("FAIL reset_outs got=%b exp=000", {irq, spi_miso, miso_oe}); end
        checks++; if ({hready, hresp} !== 3'b100) begin failures++; $display("FAIL reset_hready_hresp got=%b exp=100", {hready, hresp}); end
        @(negedge hclk); hreset = 1'b0;
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL reset_sr got=%h exp=02", rd); end
        ahb_read(5'h00, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL reset_cr got=%h exp=00", rd); end
    endtask

    task automatic test_mode0();
        logic [31:0] rd;
        logic [7:0]  mi;
        ahb_write(5'h00, 32'h01);
        ahb_write(5'h08, 32'hA5);
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h00) begin failures++; $display("FAIL m0_sr_txfull got=%h exp=00", rd); end
        set_mode(1'b0, 1'b0);
        cs_low();
        checks++; if (miso_oe !== 1'b1) begin failures++; $display("FAIL m0_miso_oe got=%b exp=1", miso_oe); end
        spi_bits(8'h3C, 8, mi);
        cs_high();
        checks++; if (mi !== 8'hA5) begin failures++; $display("FAIL m0_miso_byte got=%h exp=a5", mi); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h03) begin failures++; $display("FAIL m0_sr got=%h exp=03", rd); end
        ahb_read(5'h0C, rd);
        checks++; if (rd !== 32'h3C) begin failures++; $display("FAIL m0_rxdr got=%h exp=3c", rd); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL m0_sr_after_rd got=%h exp=02", rd); end
    endtask

    task automatic test_mode3();
        logic [31:0] rd;
        logic [7:0]  mi;
        set_mode(1'b1, 1'b1);
        ahb_write(5'h00, 32'h07);
        cs_low();
        spi_bits(8'h81, 8, mi);
        cs_high();
        checks++; if (mi !== 8'hFF) begin failures++; $display("FAIL m3_miso_dummy got=%h exp=ff", mi); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h03) begin failures++; $display("FAIL m3_sr got=%h exp=03", rd); end
        ahb_read(5'h0C, rd);
        checks++; if (rd !== 32'h81) begin failures++; $display("FAIL m3_rxdr got=%h exp=81", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [7:0]  mi0, mi1;
        ahb_write(5'h00, 32'h01);
        set_mode(1'b0, 1'b0);
        ahb_write(5'h08, 32'h5A);
        cs_low();
        spi_bits(8'h11, 8, mi0);
        spi_bits(8'h22, 8, mi1);
        cs_high();
        checks++; if (mi0 !== 8'h5A) begin failures++; $display("FAIL b2b_miso0 got=%h exp=5a", mi0); end
        checks++; if (mi1 !== 8'hFF) begin failures++; $display("FAIL b2b_miso1 got=%h exp=ff", mi1); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h0B) begin failures++; $display("FAIL b2b_sr_ovr got=%h exp=0b", rd); end
        ahb_read(5'h0C, rd);
        checks++; if (rd !== 32'h11) begin failures++; $display("FAIL b2b_rxdr got=%h exp=11", rd); end
        ahb_write(5'h04, 32'h08);
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL b2b_sr_w1c got=%h exp=02", rd); end
    endtask

    task automatic test_ferr();
        logic [31:0] rd;
        logic [7:0]  mi;
        logic        got_irq;
        ahb_write(5'h00, 32'h21);
        set_mode(1'b0, 1'b0);
        cs_low();
        spi_bits(8'hF0, 5, mi);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ferr_irq_pre got=%b exp=0", irq); end
        #50;
        spi_cs_n = 1'b1;
        got_irq = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge hclk); #1;
            if (irq === 1'b1) got_irq = 1'b1;
        end
        checks++; if (got_irq !== 1'b1) begin failures++; $display("FAIL ferr_irq_4clk got=%b exp=1", got_irq); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h12) begin failures++; $display("FAIL ferr_sr got=%h exp=12", rd); end
        ahb_write(5'h04, 32'h10);
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL ferr_sr_w1c got=%h exp=02", rd); end
        @(posedge hclk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ferr_irq_clr got=%b exp=0", irq); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic [7:0]  mi;
        ahb_write(5'h00, 32'h01);
        ahb_write(5'h08, 32'hC3);
        set_mode(1'b0, 1'b0);
        cs_low();
        spi_bits(8'hAA, 3, mi);
        @(negedge hclk); hreset = 1'b1;
        @(negedge hclk); hreset = 1'b0;
        checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL rst_mid_miso_oe got=%b exp=0", miso_oe); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL rst_mid_sr got=%h exp=02", rd); end
        cs_high();
        ahb_write(5'h00, 32'h09);
        ahb_write(5'h08, 32'h96);
        cs_low();
        spi_bits(8'hE7, 8, mi);
        cs_high();
        checks++; if (mi !== 8'h96) begin failures++; $display("FAIL rst_mid_miso got=%h exp=96", mi); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rst_mid_rx_irq got=%b exp=1", irq); end
        ahb_read(5'h04, rd);
        checks++; if (rd !== 32'h03) begin failures++; $display("FAIL rst_mid_sr2 got=%h exp=03", rd); end
        ahb_read(5'h0C, rd);
        checks++; if (rd !== 32'hE7) begin failures++; $display("FAIL rst_mid_rxdr got=%h exp=e7", rd); end
        @(posedge hclk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq_clr got=%b exp=0", irq); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_ferr();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
